// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// operand width, op codes (also used by the cpu55 decoder), FSM states.
package mdu_pkg;

    localparam int WIDTH = 32;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIX  = 2'b10,
        S_DONE = 2'b11
    } state_t;

    localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

endpackage

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit producing HI/LO; 34 cycles start->done.
// Ports: clk, rst (sync, active-low), start/op/rs_val/rt_val in; busy/done/hi_out/lo_out out.
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = mdu_pkg::WIDTH,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t state_q, state_d;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             is_div_q, is_div_d;
    logic             sa_q, sa_d;
    logic             sb_q, sb_d;
    logic [WIDTH-1:0] mag_a_q, mag_a_d;
    logic [WIDTH-1:0] mag_b_q, mag_b_d;
    logic [WIDTH-1:0] rs_q, rs_d;
    logic [WIDTH:0]   acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic               accept;
    logic               signed_in;
    logic               div_in;
    logic               sa_in;
    logic               sb_in;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_sh;
    logic [WIDTH+1:0]   div_trial;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;

    // DONE accepts a new start so back-to-back ops lose no cycle.
    assign accept = start && (state_q == S_IDLE || state_q == S_DONE);

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (start) state_d = S_CALC;
            S_CALC: if (cnt_q == LAST) state_d = S_FIX;
            S_FIX:  state_d = S_DONE;
            S_DONE: state_d = start ? S_CALC : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy = (state_q == S_CALC) || (state_q == S_FIX);
        done = (state_q == S_DONE);
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            mag_a_q  <= '0;
            mag_b_q  <= '0;
            rs_q     <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            mag_a_q  <= mag_a_d;
            mag_b_q  <= mag_b_d;
            rs_q     <= rs_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    // Datapath next-state
    always_comb begin
        signed_in = (op == OP_MULT) || (op == OP_DIV);
        div_in    = (op == OP_DIV) || (op == OP_DIVU);
        sa_in     = signed_in && rs_val[WIDTH-1];
        sb_in     = signed_in && rt_val[WIDTH-1];

        // Shift-add step: add |rs| into the high half when the multiplier LSB is set.
        mul_sum = {1'b0, acc_hi_q[WIDTH-1:0]}
                + (acc_lo_q[0] ? {1'b0, mag_a_q} : '0);

        // Restoring step: MSB of the trial difference is the borrow.
        div_sh    = {acc_hi_q[WIDTH-1:0], acc_lo_q[WIDTH-1]};
        div_trial = {1'b0, div_sh} - {2'b00, mag_b_q};

        prod     = {acc_hi_q[WIDTH-1:0], acc_lo_q};
        prod_fix = (sa_q ^ sb_q) ? -prod : prod;

        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        mag_a_d  = mag_a_q;
        mag_b_d  = mag_b_q;
        rs_d     = rs_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        hi_d     = hi_q;
        lo_d     = lo_q;

        if (accept) begin
            cnt_d    = '0;
            is_div_d = div_in;
            sa_d     = sa_in;
            sb_d     = sb_in;
            mag_a_d  = sa_in ? -rs_val : rs_val;
            mag_b_d  = sb_in ? -rt_val : rt_val;
            rs_d     = rs_val;
            acc_hi_d = '0;
            acc_lo_d = div_in ? mag_a_d : mag_b_d;
        end else if (state_q == S_CALC) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (is_div_q) begin
                acc_hi_d = div_trial[WIDTH+1] ? div_sh : div_trial[WIDTH:0];
                acc_lo_d = {acc_lo_q[WIDTH-2:0], ~div_trial[WIDTH+1]};
            end else begin
                acc_hi_d = {1'b0, mul_sum[WIDTH:1]};
                acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
            end
        end else if (state_q == S_FIX) begin
            if (!is_div_q) begin
                hi_d = prod_fix[2*WIDTH-1:WIDTH];
                lo_d = prod_fix[WIDTH-1:0];
            end else if (mag_b_q == '0) begin
                hi_d = rs_q;
                lo_d = WIDTH'(DIV0_LO);
            end else begin
                hi_d = sa_q ? -acc_hi_q[WIDTH-1:0] : acc_hi_q[WIDTH-1:0];
                lo_d = (sa_q ^ sb_q) ? -acc_lo_q : acc_lo_q;
            end
        end
    end

    assign hi_out = hi_q;
    assign lo_out = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed table, corner sequences,
// and random ops against an arithmetic reference model.
module tb_mul_div_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        busy;
    logic        done;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    int n_cmp;
    int n_bad;

    mul_div_unit dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .busy   (busy),
        .done   (done),
        .hi_out (hi_out),
        .lo_out (lo_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    // Reference: plain 64-bit arithmetic; C-style truncating signed division.
    function automatic logic [63:0] model(input logic [1:0] o,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa;
        longint sb;
        longint q;
        longint r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = '0;
        case (o)
            2'b00: p = 64'(sa * sb);
            2'b01: p = {32'h0, a} * {32'h0, b};
            2'b10: begin
                if (b == 0) begin
                    p = {a, 32'hFFFF_FFFF};
                end else begin
                    q = sa / sb;
                    r = sa % sb;
                    p = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (b == 0) p = {a, 32'hFFFF_FFFF};
                else        p = {a % b, a / b};
            end
        endcase
        return p;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Drive one start pulse; returns at the negedge after the accept edge.
    task automatic issue(input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b);
        @(negedge clk);
        start  = 1'b1;
        op     = o;
        rs_val = a;
        rt_val = b;
        @(negedge clk);
        start  = 1'b0;
        op     = 2'($urandom);
        rs_val = $urandom;
        rt_val = $urandom;
    endtask

    // Counts cycles after the accept edge until done is seen (bounded).
    task automatic wait_done(input int from, output int lat);
        lat = from;
        while (!done && lat < 60) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_check(input string name, input logic [1:0] o,
                             input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] ehi, input logic [31:0] elo);
        int lat;
        issue(o, a, b);
        wait_done(0, lat);
        check({name, " latency"}, 32'(lat), 32'd33);
        check({name, " hi"}, hi_out, ehi);
        check({name, " lo"}, lo_out, elo);
        @(negedge clk);
        check({name, " done pulse"}, {31'b0, done}, 32'd0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    vec_t vecs[$];

    initial begin
        int lat;
        int errs;
        logic [63:0] m;
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  o;

        n_cmp  = 0;
        n_bad  = 0;
        rst    = 1'b0;
        start  = 1'b0;
        op     = 2'b00;
        rs_val = '0;
        rt_val = '0;

        vecs.push_back('{"multu 7x6", 2'b01, 32'd7, 32'd6, 32'h0, 32'h2A});
        vecs.push_back('{"mult -3x5", 2'b00, 32'hFFFF_FFFD, 32'd5,
                         32'hFFFF_FFFF, 32'hFFFF_FFF1});
        vecs.push_back('{"multu fffffffd x5", 2'b01, 32'hFFFF_FFFD, 32'd5,
                         32'h4, 32'hFFFF_FFF1});
        vecs.push_back('{"divu 100/7", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14});
        vecs.push_back('{"div -7/2", 2'b10, 32'hFFFF_FFF9, 32'd2,
                         32'hFFFF_FFFF, 32'hFFFF_FFFD});
        vecs.push_back('{"div min/-1", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF,
                         32'h0, 32'h8000_0000});
        vecs.push_back('{"div by zero", 2'b10, 32'h1234_5678, 32'h0,
                         32'h1234_5678, 32'hFFFF_FFFF});
        vecs.push_back('{"divu by zero", 2'b11, 32'hDEAD_BEEF, 32'h0,
                         32'hDEAD_BEEF, 32'hFFFF_FFFF});

        repeat (3) @(negedge clk);
        rst = 1'b1;
        check("reset busy", {31'b0, busy}, 32'd0);
        check("reset done", {31'b0, done}, 32'd0);
        check("reset hi", hi_out, 32'h0);
        check("reset lo", lo_out, 32'h0);

        // Cycle-exact busy/done profile for the first op.
        issue(2'b01, 32'd7, 32'd6);
        errs = 0;
        for (int c = 1; c <= 33; c++) begin
            if (busy !== 1'b1 || done !== 1'b0) errs++;
            @(negedge clk);
        end
        check("busy profile errors", 32'(errs), 32'd0);
        check("done in cycle 34", {31'b0, done}, 32'd1);
        check("busy in cycle 34", {31'b0, busy}, 32'd0);
        check("profile lo", lo_out, 32'h2A);
        @(negedge clk);

        foreach (vecs[i])
            run_check(vecs[i].name, vecs[i].op, vecs[i].rs, vecs[i].rt,
                      vecs[i].hi, vecs[i].lo);

        // Start during CALC is ignored.
        issue(2'b11, 32'd100, 32'd7);
        repeat (8) @(negedge clk);
        start  = 1'b1;
        op     = 2'b01;
        rs_val = 32'd9;
        rt_val = 32'd9;
        @(negedge clk);
        start = 1'b0;
        wait_done(9, lat);
        check("ignored start latency", 32'(lat), 32'd33);
        check("ignored start hi", hi_out, 32'd2);
        check("ignored start lo", lo_out, 32'd14);

        // Start held in the DONE cycle: old result stays until new FIX.
        start  = 1'b1;
        op     = 2'b00;
        rs_val = 32'hFFFF_FFFD;
        rt_val = 32'd5;
        @(negedge clk);
        start = 1'b0;
        check("b2b busy", {31'b0, busy}, 32'd1);
        check("b2b old lo held", lo_out, 32'd14);
        wait_done(0, lat);
        check("b2b latency", 32'(lat), 32'd33);
        check("b2b hi", hi_out, 32'hFFFF_FFFF);
        check("b2b lo", lo_out, 32'hFFFF_FFF1);
        @(negedge clk);

        // Reset in the middle of a divide.
        issue(2'b10, 32'h1234_5678, 32'd3);
        repeat (14) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("midrst busy", {31'b0, busy}, 32'd0);
        check("midrst done", {31'b0, done}, 32'd0);
        check("midrst hi", hi_out, 32'h0);
        check("midrst lo", lo_out, 32'h0);
        errs = 0;
        repeat (40) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) errs++;
        end
        check("midrst no done", 32'(errs), 32'd0);
        m = model(2'b10, 32'hFFFF_FF00, 32'd7);
        run_check("after rst div", 2'b10, 32'hFFFF_FF00, 32'd7,
                  m[63:32], m[31:0]);

        // Random ops against the reference model.
        for (int i = 0; i < 60; i++) begin
            o = 2'($urandom_range(0, 3));
            a = pick();
            b = pick();
            m = model(o, a, b);
            run_check($sformatf("rand%0d op%0d %h %h", i, o, a, b), o, a, b,
                      m[63:32], m[31:0]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
